// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Definitions shared by the ring-router blocks: packet field positions, the
//   default packet width, the ejection FSM state type and the packet
//   classification type used by the local ejection sink.
//
//   Packet layout (PACKET_SIZE = 49):
//     [48]    valid
//     [47:32] timestamp (global clk_counter value at injection)
//     [31:16] source node
//     [15:0]  destination node
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int DEFAULT_PACKET_SIZE = 49;

  localparam int PKT_VALID_BIT = 48;
  localparam int TS_MSB        = 47;
  localparam int TS_LSB        = 32;
  localparam int SRC_MSB       = 31;
  localparam int SRC_LSB       = 16;
  localparam int DST_MSB       = 15;
  localparam int DST_LSB       = 0;

  // Ejection FSM: RUN until the expected packet count is reached, then DONE
  // (sticky until reset).
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } eject_state_e;

  // What stage 1 must do with the packet held in stage 0.
  typedef enum logic [1:0] {
    CLS_DROP     = 2'd0,
    CLS_RETIRE   = 2'd1,
    CLS_MISROUTE = 2'd2
  } pkt_class_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin arbiter with a one-bit priority pointer.
//   A lone requester is always granted; when both request, the pointed-to
//   requester wins. After any grant the pointer moves to the other requester.
//   The pointer resets to requester 0. No grant is issued while rst is high.
//
//   Ports:
//     clk  in   clock, rising edge
//     rst  in   asynchronous active-high reset
//     req  in   [1:0] request vector (bit 0 = requester 0)
//     gnt  out  [1:0] one-hot grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the requester that wins a tie.
  logic prio_q;
  logic prio_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    gnt    = 2'b00;
    prio_d = prio_q;

    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end

    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/packet_eject_local.sv
// ---------------------------------------------------------------------------
// packet_eject_local
//   Local ejection sink for one ring router. Packets offered by the east and
//   west input buffers are arbitrated round-robin onto a single ejection port
//   (one packet per cycle). The granted packet is classified and its latency
//   (clk_counter - timestamp, 16-bit wrap) is captured in stage 0; stage 1
//   updates the receive statistics on the following edge. all_received goes
//   high, and stays high until reset, once the retire count reaches
//   NUM_PACKETS_EXPECTED.
//
//   Ports:
//     clk, rst                     clock / async active-high reset
//     clk_counter          in  16  global cycle count
//     east_pkt/west_pkt    in  PACKET_SIZE  offered packets
//     east_valid/west_valid in 1   offer valid
//     east_ready/west_ready out 1  packet taken this cycle (one-hot or none)
//     total_packet_recieve out 64  packets retired here (wraps)
//     total_latency        out 64  sum of retired latencies (wraps)
//     max_latency          out 16  largest retired latency
//     misroute_count       out 16  valid packets not for this node (saturates)
//     all_received         out 1   FSM is in DONE
// ---------------------------------------------------------------------------
module packet_eject_local
  import noc_pkg::*;
#(
  parameter int NUM_NODES            = 16,
  parameter int ROUTER_ID            = 0,
  parameter int PACKET_SIZE          = DEFAULT_PACKET_SIZE,
  parameter int NUM_PACKETS_EXPECTED = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            clk_counter,
  input  logic [PACKET_SIZE-1:0] east_pkt,
  input  logic                   east_valid,
  output logic                   east_ready,
  input  logic [PACKET_SIZE-1:0] west_pkt,
  input  logic                   west_valid,
  output logic                   west_ready,
  output logic [63:0]            total_packet_recieve,
  output logic [63:0]            total_latency,
  output logic [15:0]            max_latency,
  output logic [15:0]            misroute_count,
  output logic                   all_received
);

  localparam logic [63:0] EXPECTED_CNT = 64'(NUM_PACKETS_EXPECTED);

  // -------------------------------------------------------------------------
  // Arbitration: grant bit 0 = east, bit 1 = west. A grant implies the
  // matching valid, so a grant is the handshake itself.
  // -------------------------------------------------------------------------
  logic [1:0] gnt;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({west_valid, east_valid}),
    .gnt (gnt)
  );

  assign east_ready = gnt[0];
  assign west_ready = gnt[1];

  logic [PACKET_SIZE-1:0] sel_pkt;
  logic [15:0]            sel_ts;
  logic [15:0]            sel_dst;
  logic                   unused_src_parity;

  assign sel_pkt = gnt[1] ? west_pkt : east_pkt;
  assign sel_ts  = sel_pkt[TS_MSB:TS_LSB];
  assign sel_dst = sel_pkt[DST_MSB:DST_LSB];

  // The source field plays no part in ejection statistics.
  assign unused_src_parity = ^sel_pkt[SRC_MSB:SRC_LSB];

  // -------------------------------------------------------------------------
  // Stage 0: capture classification and latency on the handshake edge.
  // Only what stage 1 consumes is kept.
  // -------------------------------------------------------------------------
  logic       s0_valid_q, s0_valid_d;
  pkt_class_e s0_cls_q,   s0_cls_d;
  logic [15:0] s0_lat_q,  s0_lat_d;

  always_comb begin
    s0_valid_d = |gnt;
    // Modular subtraction handles a timestamp taken before clk_counter wrapped.
    s0_lat_d   = clk_counter - sel_ts;
    s0_cls_d   = CLS_DROP;
    if (sel_pkt[PKT_VALID_BIT]) begin
      // A destination outside the ring can never be this node.
      if ((sel_dst == 16'(ROUTER_ID)) && (sel_dst < 16'(NUM_NODES))) begin
        s0_cls_d = CLS_RETIRE;
      end else begin
        s0_cls_d = CLS_MISROUTE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: statistics update, plus the RUN/DONE FSM which watches the
  // count being written so DONE appears together with the threshold count.
  // -------------------------------------------------------------------------
  logic [63:0]  total_cnt_q, total_cnt_d;
  logic [63:0]  lat_sum_q,   lat_sum_d;
  logic [15:0]  lat_max_q,   lat_max_d;
  logic [15:0]  misroute_q,  misroute_d;
  eject_state_e state_q,     state_d;

  always_comb begin
    total_cnt_d = total_cnt_q;
    lat_sum_d   = lat_sum_q;
    lat_max_d   = lat_max_q;
    misroute_d  = misroute_q;

    if (s0_valid_q) begin
      case (s0_cls_q)
        CLS_RETIRE: begin
          total_cnt_d = total_cnt_q + 64'd1;
          lat_sum_d   = lat_sum_q + {48'd0, s0_lat_q};
          if (s0_lat_q > lat_max_q) begin
            lat_max_d = s0_lat_q;
          end
        end
        CLS_MISROUTE: begin
          if (misroute_q != 16'hFFFF) begin
            misroute_d = misroute_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && (total_cnt_d >= EXPECTED_CNT)) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_cls_q    <= CLS_DROP;
      s0_lat_q    <= 16'd0;
      total_cnt_q <= 64'd0;
      lat_sum_q   <= 64'd0;
      lat_max_q   <= 16'd0;
      misroute_q  <= 16'd0;
      state_q     <= ST_RUN;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_cls_q    <= s0_cls_d;
      s0_lat_q    <= s0_lat_d;
      total_cnt_q <= total_cnt_d;
      lat_sum_q   <= lat_sum_d;
      lat_max_q   <= lat_max_d;
      misroute_q  <= misroute_d;
      state_q     <= state_d;
    end
  end

  assign total_packet_recieve = total_cnt_q;
  assign total_latency        = lat_sum_q;
  assign max_latency          = lat_max_q;
  assign misroute_count       = misroute_q;
  assign all_received         = (state_q == ST_DONE);

endmodule
